// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter: two request ports with
// valid/ready handshakes and a shared registered response bus.
interface alu_share_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 4
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [WIDTH-1:0]      req0_a;
  logic [WIDTH-1:0]      req0_b;
  logic [CTRL_WIDTH-1:0] req0_ctrl;
  logic [WIDTH-1:0]      req1_a;
  logic [WIDTH-1:0]      req1_b;
  logic [CTRL_WIDTH-1:0] req1_ctrl;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;

  // Requester view: drives requests and response consumption.
  modport master (
    output req_valid, req0_a, req0_b, req0_ctrl,
           req1_a, req1_b, req1_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  // Arbiter view: grants requests and returns responses.
  modport slave (
    input  req_valid, req0_a, req0_b, req0_ctrl,
           req1_a, req1_b, req1_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one single-cycle ALU between two requesters.
// A granted request is latched, executed for one cycle, and its registered
// result/zero flag is returned to the owner over a valid/ready response.
module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_share_arbiter_if.slave    bus,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic [WIDTH-1:0]      lat_a;
  logic [WIDTH-1:0]      lat_b;
  logic [CTRL_WIDTH-1:0] lat_ctrl;
  logic [WIDTH-1:0]      result_q;
  logic                  zero_q;
  logic [1:0]            rsp_valid_q;
  logic                  busy_q;

  logic                  grant;
  logic [1:0]            ready;
  logic                  accept;

  // Pick the winner: a lone requester wins, a tie goes to the port that did not win last.
  always_comb begin
    grant = 1'b0;
    ready = 2'b00;
    if (bus.req_valid == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = ~bus.req_valid[0];
    end
    if ((state == IDLE) && (|bus.req_valid)) begin
      ready = grant ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(bus.req_valid & ready);

  // Transaction sequencer: latch winner, run the ALU one cycle, hold the response until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_ctrl    <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_a      <= grant ? bus.req1_a    : bus.req0_a;
            lat_b      <= grant ? bus.req1_b    : bus.req0_b;
            lat_ctrl   <= grant ? bus.req1_ctrl : bus.req0_ctrl;
            owner      <= grant;
            last_grant <= grant;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_result;
          zero_q      <= alu_zero;
          rsp_valid_q <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner]) begin
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign alu_a          = lat_a;
  assign alu_b          = lat_b;
  assign alu_ctrl       = lat_ctrl;
  assign busy           = busy_q;

endmodule
